// File: rtl/multi_lane_deserializer_pkg.sv
// Shared USB4 logical-layer constants: gen_speed codes, symbol widths and
// the maximum per-lane word width.
package multi_lane_deserializer_pkg;

    localparam int unsigned SYM_W_MAX  = 132;
    localparam int unsigned SYM_W_GEN4 = 8;
    localparam int unsigned SYM_W_GEN3 = 132;
    localparam int unsigned SYM_W_GEN2 = 66;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic [1:0] {
        GenSym8    = 2'b00,
        GenSym132  = 2'b01,
        GenSym66   = 2'b10,
        GenSym8Alt = 2'b11
    } gen_speed_e;

    function automatic logic [CNT_W-1:0] sym_width(input logic [1:0] code);
        logic [CNT_W-1:0] w;
        case (gen_speed_e'(code))
            GenSym132: w = CNT_W'(SYM_W_GEN3);
            GenSym66:  w = CNT_W'(SYM_W_GEN2);
            default:   w = CNT_W'(SYM_W_GEN4);
        endcase
        return w;
    endfunction

endpackage

// File: rtl/multi_lane_deserializer_if.sv
// Parallel word-set output bus with a valid/ready handshake.
interface multi_lane_deserializer_if #(
    parameter int unsigned NUM_LANES = 2
);
    import multi_lane_deserializer_pkg::*;

    logic [NUM_LANES*SYM_W_MAX-1:0] rx_out;
    logic                           out_valid;
    logic                           out_ready;

    modport master (output rx_out, output out_valid, input out_ready);
    modport slave  (input rx_out, input out_valid, output out_ready);

endinterface

// File: rtl/multi_lane_deserializer_lane_shift_reg.sv
// Per-lane LSB-first shifter: new bits enter at the MSB, so after W shifts the
// word sits in the top W bits with the first received bit lowest.
module lane_shift_reg #(
    parameter int unsigned WIDTH = 132
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             clr,
    input  logic             din,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else if (clr) begin
            data_q <= '0;
        end else if (shift) begin
            data_q <= {din, data_q[WIDTH-1:1]};
        end
    end

    assign data = data_q;

endmodule

// File: rtl/multi_lane_deserializer.sv
// Multi-lane serial-to-parallel deserializer with selectable symbol width,
// valid/ready output handshake and sticky overrun on dropped word sets.
module multi_lane_deserializer
    import multi_lane_deserializer_pkg::*;
#(
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned MAX_SYM_W = SYM_W_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [1:0]           gen_speed,
    input  logic [NUM_LANES-1:0] lane_mask,
    input  logic [NUM_LANES-1:0] rx_in,
    output logic                 descr_rst,
    output logic                 overrun,
    input  logic                 clr_ovr,
    multi_lane_deserializer_if.master bus
);

    logic [CNT_W-1:0] w, w_q, shamt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       speed_q;
    logic             en_q, done_q, done_d, valid_q, valid_d, ovr_q, ovr_d;
    logic             change, shift_en, last, load, drop;
    logic [NUM_LANES*MAX_SYM_W-1:0] rx_out_q, rx_out_d;
    logic [MAX_SYM_W-1:0]           sr [NUM_LANES];

    assign w     = sym_width(gen_speed);
    // Width the just-completed word was captured with.
    assign w_q   = sym_width(speed_q);
    assign shamt = CNT_W'(MAX_SYM_W) - w_q;

    // en_q gates change detection so a fresh enable always starts at count 0.
    assign change   = enable & en_q & (gen_speed != speed_q);
    assign shift_en = enable & ~change;
    assign last     = (cnt_q == w - CNT_W'(1));
    assign done_d   = shift_en & last;
    assign load     = enable & done_q & (~valid_q | bus.out_ready);
    assign drop     = enable & done_q & valid_q & ~bus.out_ready;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_shift_reg #(
            .WIDTH (MAX_SYM_W)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .shift (shift_en),
            .clr   (~shift_en),
            .din   (rx_in[i]),
            .data  (sr[i])
        );
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!shift_en || last) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (!enable) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        ovr_d = ovr_q;
        if (drop) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    always_comb begin
        rx_out_d = rx_out_q;
        if (!enable) begin
            rx_out_d = '0;
        end else if (load) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                rx_out_d[i*MAX_SYM_W +: MAX_SYM_W] = lane_mask[i] ? (sr[i] >> shamt) : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            speed_q  <= '0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            rx_out_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            speed_q  <= gen_speed;
            en_q     <= enable;
            done_q   <= done_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            rx_out_q <= rx_out_d;
        end
    end

    assign descr_rst     = shift_en & (cnt_q == w - CNT_W'(2));
    assign overrun       = ovr_q;
    assign bus.rx_out    = rx_out_q;
    assign bus.out_valid = valid_q;

endmodule
